// File: rtl/ball_ctrl_pkg.sv
// Shared field geometry, FSM state type and helpers for the pong ball controller.
// Field values mirror the VGA display configuration (640x480 visible, 40-pixel border).
package ball_ctrl_pkg;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned SCORE_W    = 4;
  localparam int unsigned H_DISP     = 640;
  localparam int unsigned V_DISP     = 480;
  localparam int unsigned SLDE_W     = 40;
  localparam int unsigned DEF_BALL_W = 10;
  localparam int unsigned DEF_BODY_W = 10;
  localparam int unsigned DEF_BODY_L = 80;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  // 2-bit score increment that sticks at 3
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/ball_ctrl_serve_timer.sv
// Counts enabled frame ticks while serving; done fires on the tick that reaches SERVE_FRAMES-1.
module ball_ctrl_serve_timer #(
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done_c
);

  localparam int unsigned CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SERVE_FRAMES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_done_c = i_en && (r_cnt == LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_done_c ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ball_ctrl.sv
// Pong ball physics and score keeper: moves the ball once per frame tick, bounces it off
// the border and paddles, scores misses, re-serves from centre and stops at WIN_SCORE.
module ball_ctrl
  import ball_ctrl_pkg::*;
#(
  parameter int unsigned BALL_W       = DEF_BALL_W,
  parameter int unsigned PAD_W        = DEF_BODY_W,
  parameter int unsigned PAD_L        = DEF_BODY_L,
  parameter int unsigned PAD0_X       = 50,
  parameter int unsigned PAD1_X       = 580,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 3
) (
  input  logic               vga_clk,
  input  logic               sys_rst_n,
  input  logic               frame_tick,
  input  logic               start,
  input  logic               s,
  input  logic [COORD_W-1:0] padbody_y0,
  input  logic [COORD_W-1:0] padbody_y1,
  output logic [COORD_W-1:0] ball_x,
  output logic [COORD_W-1:0] ball_y,
  output logic [SCORE_W-1:0] score,
  output logic               guiwei,
  output logic               game_over
);

  // One extra bit so sums are compared before they can wrap
  localparam int unsigned XW = COORD_W + 1;

  localparam logic [COORD_W-1:0] CX       = COORD_W'((H_DISP - BALL_W) / 2);
  localparam logic [COORD_W-1:0] CY       = COORD_W'((V_DISP - BALL_W) / 2);
  localparam logic [COORD_W-1:0] SPD10    = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] TOP_Y    = COORD_W'(SLDE_W);
  localparam logic [COORD_W-1:0] BOT_Y    = COORD_W'(V_DISP - SLDE_W - BALL_W);
  localparam logic [COORD_W-1:0] PAD0_OUT = COORD_W'(PAD0_X + PAD_W);
  localparam logic [COORD_W-1:0] PAD1_OUT = COORD_W'(PAD1_X - BALL_W);

  localparam logic [XW-1:0] K_SPEED   = XW'(SPEED);
  localparam logic [XW-1:0] K_BALL    = XW'(BALL_W);
  localparam logic [XW-1:0] K_PAD_L   = XW'(PAD_L);
  localparam logic [XW-1:0] K_TOP_LIM = XW'(SLDE_W + SPEED);
  localparam logic [XW-1:0] K_BOT_LIM = XW'(V_DISP - SLDE_W);
  localparam logic [XW-1:0] K_PAD0_E  = XW'(PAD0_X + PAD_W);
  localparam logic [XW-1:0] K_PAD1_E  = XW'(PAD1_X);
  localparam logic [XW-1:0] K_MISS_L  = XW'(SLDE_W);
  localparam logic [XW-1:0] K_MISS_R  = XW'(H_DISP - SLDE_W);
  localparam logic [1:0]    K_WIN     = 2'(WIN_SCORE);

  state_t r_state;
  state_t w_state_nxt;

  logic [COORD_W-1:0] r_ball_x;
  logic [COORD_W-1:0] r_ball_y;
  logic               r_dx_neg;
  logic               r_dy_neg;
  logic [SCORE_W-1:0] r_score;
  logic               r_guiwei;
  logic               r_game_over;

  logic               w_run;
  logic               w_serve_en;
  logic               w_serve_clr;
  logic               w_serve_done;
  logic [XW-1:0]      w_bx;
  logic [XW-1:0]      w_by;
  logic [XW-1:0]      w_rx;
  logic [COORD_W-1:0] w_nx;
  logic [COORD_W-1:0] w_ny;
  logic               w_dx_neg;
  logic               w_dy_neg;
  logic               w_ovl0;
  logic               w_ovl1;
  logic               w_hit_l;
  logic               w_hit_r;
  logic               w_pt_l;
  logic               w_pt_r;

  assign w_run       = frame_tick && !s;
  assign w_serve_en  = (r_state == ST_SERVE) && w_run;
  assign w_serve_clr = (r_state != ST_SERVE);

  ball_ctrl_serve_timer #(
    .SERVE_FRAMES(SERVE_FRAMES)
  ) u_serve_timer (
    .i_clk   (vga_clk),
    .i_rst_n (sys_rst_n),
    .i_clr   (w_serve_clr),
    .i_en    (w_serve_en),
    .o_done_c(w_serve_done)
  );

  // Candidate next position/direction for one play tick, with wall, paddle and miss tests
  always_comb begin
    w_bx     = {1'b0, r_ball_x};
    w_by     = {1'b0, r_ball_y};
    w_rx     = r_dx_neg ? (w_bx - K_SPEED) : (w_bx + K_SPEED);
    w_nx     = w_rx[COORD_W-1:0];
    w_ny     = r_dy_neg ? (r_ball_y - SPD10) : (r_ball_y + SPD10);
    w_dx_neg = r_dx_neg;
    w_dy_neg = r_dy_neg;
    w_ovl0   = ((w_by + K_BALL) > {1'b0, padbody_y0}) && (w_by < ({1'b0, padbody_y0} + K_PAD_L));
    w_ovl1   = ((w_by + K_BALL) > {1'b0, padbody_y1}) && (w_by < ({1'b0, padbody_y1} + K_PAD_L));
    w_hit_l  = r_dx_neg && (w_bx >= K_PAD0_E) && (w_rx < K_PAD0_E) && w_ovl0;
    w_hit_r  = !r_dx_neg && ((w_bx + K_BALL) <= K_PAD1_E) && ((w_rx + K_BALL) > K_PAD1_E) && w_ovl1;
    w_pt_r   = r_dx_neg && !w_hit_l && (w_rx <= K_MISS_L);
    w_pt_l   = !r_dx_neg && !w_hit_r && ((w_rx + K_BALL) >= K_MISS_R);

    if (r_dy_neg && (w_by < K_TOP_LIM)) begin
      w_ny     = TOP_Y;
      w_dy_neg = 1'b0;
    end
    if (!r_dy_neg && ((w_by + K_BALL + K_SPEED) > K_BOT_LIM)) begin
      w_ny     = BOT_Y;
      w_dy_neg = 1'b1;
    end
    if (w_hit_l) begin
      w_nx     = PAD0_OUT;
      w_dx_neg = 1'b0;
    end
    if (w_hit_r) begin
      w_nx     = PAD1_OUT;
      w_dx_neg = 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Dropping start aborts from any state
  always_comb begin
    w_state_nxt = r_state;
    if (!start) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_SERVE;
        ST_SERVE: if (w_serve_done) w_state_nxt = ST_PLAY;
        ST_PLAY:  if (w_run && (w_pt_l || w_pt_r)) w_state_nxt = ST_POINT;
        ST_POINT: w_state_nxt = ((r_score[3:2] == K_WIN) || (r_score[1:0] == K_WIN)) ? ST_OVER : ST_SERVE;
        ST_OVER:  w_state_nxt = ST_OVER;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Score and guiwei are updated on the miss edge so they are visible during POINT
  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      r_ball_x    <= CX;
      r_ball_y    <= CY;
      r_dx_neg    <= 1'b0;
      r_dy_neg    <= 1'b0;
      r_score     <= '0;
      r_guiwei    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_guiwei    <= 1'b0;
      r_game_over <= (w_state_nxt == ST_OVER);
      if (!start) begin
        r_ball_x <= CX;
        r_ball_y <= CY;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_score  <= '0;
            r_ball_x <= CX;
            r_ball_y <= CY;
          end
          ST_PLAY: begin
            if (w_run) begin
              if (w_pt_l || w_pt_r) begin
                r_ball_x <= CX;
                r_ball_y <= CY;
                r_guiwei <= 1'b1;
                r_dx_neg <= w_pt_r;
                if (w_pt_l) r_score[3:2] <= sat_inc2(r_score[3:2]);
                else        r_score[1:0] <= sat_inc2(r_score[1:0]);
              end else begin
                r_ball_x <= w_nx;
                r_ball_y <= w_ny;
                r_dx_neg <= w_dx_neg;
                r_dy_neg <= w_dy_neg;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ball_x    = r_ball_x;
  assign ball_y    = r_ball_y;
  assign score     = r_score;
  assign guiwei    = r_guiwei;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_ball_ctrl.sv
// Bench for ball_ctrl: integer-arithmetic game model, directed scenarios and random play.
module tb_ball_ctrl;

  localparam int CX = 315, CY = 235, SPEED = 2, BALL_W = 10, SLDE_W = 40;
  localparam int V_DISP = 480, H_DISP = 640, PAD0_X = 50, PAD1_X = 580;
  localparam int PAD_W = 10, PAD_L = 80, SERVE_FRAMES = 60, WIN = 3;
  localparam int PH_IDLE = 0, PH_SERVE = 1, PH_PLAY = 2, PH_POINT = 3, PH_OVER = 4;

  logic       vga_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       s = 1'b0;
  logic [9:0] padbody_y0 = '0;
  logic [9:0] padbody_y1 = '0;
  logic [9:0] ball_x, ball_y;
  logic [3:0] score;
  logic       guiwei, game_over;

  int checks = 0;
  int failures = 0;

  // Game model: position, unit directions, scores, phase, serve ticks
  int m_x, m_y, m_dx, m_dy, m_l, m_r, m_ph, m_cnt, m_gw;
  int pad_mode = 0;  // 0 track both, 1 left misses, 2 right misses, 3 fixed random

  wire [25:0] dut_v = {ball_x, ball_y, score, guiwei, game_over};

  ball_ctrl dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .frame_tick(frame_tick),
    .start     (start),
    .s         (s),
    .padbody_y0(padbody_y0),
    .padbody_y1(padbody_y1),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .score     (score),
    .guiwei    (guiwei),
    .game_over (game_over)
  );

  always #5 vga_clk = ~vga_clk;

  function automatic int track_y(input int y);
    return (y >= 20) ? y - 20 : 0;
  endfunction

  function automatic int far_y(input int y);
    return (y > 150) ? 0 : 400;
  endfunction

  function automatic logic [25:0] expv();
    return {10'(m_x), 10'(m_y), 2'(m_l), 2'(m_r), 1'(m_gw), 1'(m_ph == PH_OVER)};
  endfunction

  task automatic model_reset();
    m_ph = PH_IDLE; m_x = CX; m_y = CY; m_dx = 1; m_dy = 1;
    m_l = 0; m_r = 0; m_cnt = 0; m_gw = 0;
  endtask

  task automatic play_tick();
    int nx, ny, ndx, ndy, p0, p1;
    p0 = int'(padbody_y0);
    p1 = int'(padbody_y1);
    nx = m_x + SPEED * m_dx;
    ny = m_y + SPEED * m_dy;
    ndx = m_dx;
    ndy = m_dy;
    if (m_dy < 0 && m_y < SLDE_W + SPEED) begin ny = SLDE_W; ndy = 1; end
    if (m_dy > 0 && m_y + BALL_W + SPEED > V_DISP - SLDE_W) begin ny = V_DISP - SLDE_W - BALL_W; ndy = -1; end
    if (m_dx < 0 && m_x >= PAD0_X + PAD_W && nx < PAD0_X + PAD_W && m_y + BALL_W > p0 && m_y < p0 + PAD_L) begin
      nx = PAD0_X + PAD_W; ndx = 1;
    end else if (m_dx > 0 && m_x + BALL_W <= PAD1_X && nx + BALL_W > PAD1_X && m_y + BALL_W > p1 && m_y < p1 + PAD_L) begin
      nx = PAD1_X - BALL_W; ndx = -1;
    end
    if (m_dx < 0 && nx <= SLDE_W) begin
      m_r = (m_r < 3) ? m_r + 1 : 3;
      m_ph = PH_POINT; m_gw = 1; m_x = CX; m_y = CY; m_dx = -1;
    end else if (m_dx > 0 && nx + BALL_W >= H_DISP - SLDE_W) begin
      m_l = (m_l < 3) ? m_l + 1 : 3;
      m_ph = PH_POINT; m_gw = 1; m_x = CX; m_y = CY; m_dx = 1;
    end else begin
      m_x = nx; m_y = ny; m_dx = ndx; m_dy = ndy;
    end
  endtask

  task automatic model_step();
    if (!sys_rst_n) begin
      model_reset();
      return;
    end
    m_gw = 0;
    if (!start) begin
      m_ph = PH_IDLE; m_x = CX; m_y = CY; m_cnt = 0;
    end else begin
      case (m_ph)
        PH_IDLE:  begin m_ph = PH_SERVE; m_l = 0; m_r = 0; m_cnt = 0; end
        PH_SERVE: if (frame_tick && !s) begin
                    if (m_cnt == SERVE_FRAMES - 1) begin m_ph = PH_PLAY; m_cnt = 0; end
                    else m_cnt++;
                  end
        PH_PLAY:  if (frame_tick && !s) play_tick();
        PH_POINT: begin m_ph = (m_l == WIN || m_r == WIN) ? PH_OVER : PH_SERVE; m_cnt = 0; end
        default:  ;
      endcase
    end
  endtask

  // Drive one clock: paddles per mode, edge, advance model, settle
  task automatic step(input logic tk);
    frame_tick = tk;
    case (pad_mode)
      0: begin padbody_y0 = 10'(track_y(m_y)); padbody_y1 = 10'(track_y(m_y)); end
      1: begin padbody_y0 = 10'(far_y(m_y));   padbody_y1 = 10'(track_y(m_y)); end
      2: begin padbody_y0 = 10'(track_y(m_y)); padbody_y1 = 10'(far_y(m_y));   end
      default: ;
    endcase
    @(posedge vga_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; start = 1'b1; s = 1'b0; pad_mode = 0;
    step(0);
    step(1);
    checks++;
    if (ball_x !== 10'd315 || ball_y !== 10'd235) begin
      failures++; $display("FAIL reset_pos got=(%0d,%0d) want=(315,235)", ball_x, ball_y);
    end
    checks++;
    if (score !== 4'd0 || guiwei !== 1'b0 || game_over !== 1'b0) begin
      failures++; $display("FAIL reset_flags got score=%b gw=%b go=%b want 0000/0/0", score, guiwei, game_over);
    end
    sys_rst_n = 1'b1;
  endtask

  task automatic test_serve();
    int moved = 0;
    step(0);
    for (int i = 0; i < SERVE_FRAMES; i++) begin
      step(1);
      if (ball_x !== 10'd315 || ball_y !== 10'd235) moved++;
      step(0);
    end
    checks++;
    if (moved != 0) begin
      failures++; $display("FAIL serve_hold got moved_ticks=%0d want 0", moved);
    end
    step(1);
    checks++;
    if (ball_x !== 10'd317 || ball_y !== 10'd237) begin
      failures++; $display("FAIL serve_first_move got=(%0d,%0d) want=(317,237)", ball_x, ball_y);
    end
  endtask

  task automatic test_top_bounce();
    int found = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      if (m_ph == PH_PLAY && m_y == 42 && m_dy < 0) found = 1;
      else begin
        step(1'(i % 2));
        checks++;
        if (dut_v !== expv()) begin failures++; $display("FAIL top_run dut=%h exp=%h", dut_v, expv()); end
      end
    end
    checks++;
    if (found == 0) begin failures++; $display("FAIL top_timeout got no y=42 want reached"); return; end
    step(1);
    checks++;
    if (ball_y !== 10'd40) begin failures++; $display("FAIL top_t1 got=%0d want=40", ball_y); end
    step(0); step(1);
    checks++;
    if (ball_y !== 10'd40) begin failures++; $display("FAIL top_t2 got=%0d want=40", ball_y); end
    step(0); step(1);
    checks++;
    if (ball_y !== 10'd42) begin failures++; $display("FAIL top_t3 got=%0d want=42", ball_y); end
  endtask

  task automatic test_miss();
    int found = 0;
    pad_mode = 1;
    for (int i = 0; i < 6000 && found == 0; i++) begin
      step(1'(i % 2));
      checks++;
      if (dut_v !== expv()) begin failures++; $display("FAIL miss_run dut=%h exp=%h", dut_v, expv()); end
      if (m_gw == 1) found = 1;
    end
    checks++;
    if (found == 0) begin failures++; $display("FAIL miss_timeout got no point want point"); return; end
    checks++;
    if (guiwei !== 1'b1 || score !== 4'b0001 || ball_x !== 10'd315 || ball_y !== 10'd235) begin
      failures++; $display("FAIL miss_point got gw=%b score=%b pos=(%0d,%0d) want 1/0001/(315,235)", guiwei, score, ball_x, ball_y);
    end
    pad_mode = 0;
    step(0);
    checks++;
    if (guiwei !== 1'b0) begin failures++; $display("FAIL miss_gw_pulse got=%b want=0", guiwei); end
    for (int i = 0; i < SERVE_FRAMES; i++) begin step(1); step(0); end
    step(1);
    checks++;
    if (ball_x !== 10'd313) begin failures++; $display("FAIL miss_serve_dir got x=%0d want=313", ball_x); end
  endtask

  task automatic test_paddle();
    int found = 0;
    pad_mode = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      if (m_ph == PH_PLAY && m_x == 61 && m_dx < 0) found = 1;
      else begin
        step(1'(i % 2));
        checks++;
        if (dut_v !== expv()) begin failures++; $display("FAIL pad_run dut=%h exp=%h", dut_v, expv()); end
      end
    end
    checks++;
    if (found == 0) begin failures++; $display("FAIL pad_timeout got no x=61 want reached"); return; end
    step(1);
    checks++;
    if (ball_x !== 10'd60 || guiwei !== 1'b0) begin
      failures++; $display("FAIL pad_hit got x=%0d gw=%b want 60/0", ball_x, guiwei);
    end
    step(0); step(1);
    checks++;
    if (ball_x !== 10'd62) begin failures++; $display("FAIL pad_rebound got x=%0d want=62", ball_x); end
  endtask

  task automatic test_pause();
    int px, py, bad = 0;
    px = m_x; py = m_y;
    s = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (int'(ball_x) != px || int'(ball_y) != py) bad++;
      step(0);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL pause_freeze got moved=%0d want 0", bad); end
    s = 1'b0;
    step(1);
    checks++;
    if (dut_v !== expv()) begin failures++; $display("FAIL pause_resume dut=%h exp=%h", dut_v, expv()); end
    start = 1'b0;
    step(1);
    checks++;
    if (ball_x !== 10'd315 || ball_y !== 10'd235 || score !== 4'b0001) begin
      failures++; $display("FAIL abort got pos=(%0d,%0d) score=%b want (315,235)/0001", ball_x, ball_y, score);
    end
    step(0); step(1);
    checks++;
    if (ball_x !== 10'd315 || ball_y !== 10'd235) begin
      failures++; $display("FAIL idle_hold got=(%0d,%0d) want=(315,235)", ball_x, ball_y);
    end
    start = 1'b1;
    step(0);
    checks++;
    if (score !== 4'd0) begin failures++; $display("FAIL restart_clear got=%b want=0000", score); end
  endtask

  task automatic test_game_over();
    int found = 0, bad = 0;
    pad_mode = 2;
    for (int i = 0; i < 12000 && found == 0; i++) begin
      step(1'(i % 2));
      checks++;
      if (dut_v !== expv()) begin failures++; $display("FAIL over_run dut=%h exp=%h", dut_v, expv()); end
      if (m_ph == PH_OVER) found = 1;
    end
    checks++;
    if (found == 0) begin failures++; $display("FAIL over_timeout got no OVER want OVER"); return; end
    checks++;
    if (score !== 4'b1100 || game_over !== 1'b1 || ball_x !== 10'd315 || ball_y !== 10'd235) begin
      failures++; $display("FAIL over_state got score=%b go=%b pos=(%0d,%0d) want 1100/1/(315,235)", score, game_over, ball_x, ball_y);
    end
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (game_over !== 1'b1 || ball_x !== 10'd315 || ball_y !== 10'd235 || score !== 4'b1100) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL over_hold got bad=%0d want 0", bad); end
    start = 1'b0;
    step(0);
    checks++;
    if (game_over !== 1'b0 || score !== 4'b1100) begin
      failures++; $display("FAIL over_exit got go=%b score=%b want 0/1100", game_over, score);
    end
    start = 1'b1;
    step(0);
    checks++;
    if (score !== 4'd0) begin failures++; $display("FAIL over_restart got=%b want=0000", score); end
    pad_mode = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8000; i++) begin
      if (i % 300 == 0) begin
        pad_mode = int'($urandom_range(0, 3));
        if (pad_mode == 3) begin
          padbody_y0 = 10'($urandom_range(0, 500));
          padbody_y1 = 10'($urandom_range(0, 500));
        end
      end
      sys_rst_n = ($urandom_range(0, 2999) != 0);
      start     = ($urandom_range(0, 1499) != 0);
      s         = ($urandom_range(0, 9) == 0);
      step(1'($urandom_range(0, 2) == 0));
      checks++;
      if (dut_v !== expv()) begin failures++; $display("FAIL random i=%0d dut=%h exp=%h", i, dut_v, expv()); end
    end
    sys_rst_n = 1'b1; start = 1'b1; s = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_serve();
    test_top_bounce();
    test_miss();
    test_paddle();
    test_pause();
    test_game_over();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
